// File: rtl/morse_element_detector_pkg.sv
// Shared encodings and default timing constants for the Morse element detector.
package morse_element_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_WGAP  = 2'd3
    } state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int DEF_TIMER_BITS  = 8;
    localparam int DEF_DOT_MAX     = 3;
    localparam int DEF_LETTER_GAP  = 3;
    localparam int DEF_WORD_GAP    = 7;
    localparam int DEF_MAX_SYMBOLS = 5;
    localparam int DEF_LEN_BITS    = 3;

endpackage

// File: rtl/morse_element_detector_if.sv
// Key/tick inputs and element/letter/word strobes of the Morse element detector.
interface morse_element_detector_if
    import morse_element_detector_pkg::*;
#(
    parameter int MAX_SYMBOLS = DEF_MAX_SYMBOLS,
    parameter int LEN_BITS    = DEF_LEN_BITS
);
    logic                   tick;
    logic                   key;
    logic                   sym_valid;
    logic                   sym_is_dash;
    logic                   letter_valid;
    logic [MAX_SYMBOLS-1:0] letter_code;
    logic [LEN_BITS-1:0]    letter_len;
    logic                   letter_err;
    logic                   word_gap;

    modport master (
        output tick, key,
        input  sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, letter_err, word_gap
    );

    modport slave (
        input  tick, key,
        output sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, letter_err, word_gap
    );
endinterface

// File: rtl/morse_element_detector_tick_timer.sv
// Saturating tick counter with synchronous clear; measures mark and space durations.
module morse_element_detector_tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             tick,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/morse_element_detector.sv
// Morse timing front end: classifies marks and spaces, assembles letters, flags word gaps.
module morse_element_detector
    import morse_element_detector_pkg::*;
#(
    parameter int TIMER_BITS  = DEF_TIMER_BITS,
    parameter int DOT_MAX     = DEF_DOT_MAX,
    parameter int LETTER_GAP  = DEF_LETTER_GAP,
    parameter int WORD_GAP    = DEF_WORD_GAP,
    parameter int MAX_SYMBOLS = DEF_MAX_SYMBOLS,
    parameter int LEN_BITS    = DEF_LEN_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    morse_element_detector_if.slave  bus
);
    localparam logic [TIMER_BITS-1:0] DOT_MAX_T   = TIMER_BITS'(DOT_MAX);
    localparam logic [TIMER_BITS-1:0] LETTER_TICK = TIMER_BITS'(LETTER_GAP - 1);
    localparam logic [TIMER_BITS-1:0] WORD_TICK   = TIMER_BITS'(WORD_GAP - 1);
    localparam logic [LEN_BITS-1:0]   MAX_LEN     = LEN_BITS'(MAX_SYMBOLS);

    logic                   key_q, key_d;
    logic                   rise, fall;
    logic [TIMER_BITS-1:0]  timer;
    state_e                 state_q, state_d;
    logic [MAX_SYMBOLS-1:0] code_q, code_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic                   ovf_q, ovf_d;

    logic                   sym_valid_q, sym_valid_d;
    logic                   sym_is_dash_q, sym_is_dash_d;
    logic                   letter_valid_q, letter_valid_d;
    logic [MAX_SYMBOLS-1:0] letter_code_q, letter_code_d;
    logic [LEN_BITS-1:0]    letter_len_q, letter_len_d;
    logic                   letter_err_q, letter_err_d;
    logic                   word_gap_q, word_gap_d;

    assign key_d = bus.key;
    assign rise  = bus.key & ~key_q;
    assign fall  = ~bus.key & key_q;

    morse_element_detector_tick_timer #(
        .WIDTH (TIMER_BITS)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (rise | fall),
        .tick    (bus.tick),
        .count   (timer)
    );

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        len_d          = len_q;
        ovf_d          = ovf_q;
        sym_valid_d    = 1'b0;
        sym_is_dash_d  = sym_is_dash_q;
        letter_valid_d = 1'b0;
        letter_code_d  = letter_code_q;
        letter_len_d   = letter_len_q;
        letter_err_d   = letter_err_q;
        word_gap_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_MARK;
            end
            ST_MARK: begin
                if (fall) begin
                    // Classification uses the mark length before the edge clears the timer.
                    sym_valid_d   = 1'b1;
                    sym_is_dash_d = (timer >= DOT_MAX_T) ? SYM_DASH : SYM_DOT;
                    if (len_q < MAX_LEN) begin
                        code_d = {code_q[MAX_SYMBOLS-2:0], sym_is_dash_d};
                        len_d  = len_q + LEN_BITS'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    state_d = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (bus.tick && (timer == LETTER_TICK)) begin
                    letter_valid_d = 1'b1;
                    letter_code_d  = code_q;
                    letter_len_d   = len_q;
                    letter_err_d   = ovf_q;
                    code_d         = '0;
                    len_d          = '0;
                    ovf_d          = 1'b0;
                    state_d        = ST_WGAP;
                end
                // A new mark wins the next state even when the letter closes this cycle.
                if (rise) state_d = ST_MARK;
            end
            ST_WGAP: begin
                if (rise) begin
                    state_d = ST_MARK;
                end else if (bus.tick && (timer == WORD_TICK)) begin
                    word_gap_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q          <= 1'b0;
            state_q        <= ST_IDLE;
            code_q         <= '0;
            len_q          <= '0;
            ovf_q          <= 1'b0;
            sym_valid_q    <= 1'b0;
            sym_is_dash_q  <= 1'b0;
            letter_valid_q <= 1'b0;
            letter_code_q  <= '0;
            letter_len_q   <= '0;
            letter_err_q   <= 1'b0;
            word_gap_q     <= 1'b0;
        end else begin
            key_q          <= key_d;
            state_q        <= state_d;
            code_q         <= code_d;
            len_q          <= len_d;
            ovf_q          <= ovf_d;
            sym_valid_q    <= sym_valid_d;
            sym_is_dash_q  <= sym_is_dash_d;
            letter_valid_q <= letter_valid_d;
            letter_code_q  <= letter_code_d;
            letter_len_q   <= letter_len_d;
            letter_err_q   <= letter_err_d;
            word_gap_q     <= word_gap_d;
        end
    end

    assign bus.sym_valid    = sym_valid_q;
    assign bus.sym_is_dash  = sym_is_dash_q;
    assign bus.letter_valid = letter_valid_q;
    assign bus.letter_code  = letter_code_q;
    assign bus.letter_len   = letter_len_q;
    assign bus.letter_err   = letter_err_q;
    assign bus.word_gap     = word_gap_q;
endmodule
